display_counter: RTL and testbench

Four-digit start/stop counter that generates the 4-bit digit values driven into the board's per-digit hex decoders (digit0 → HEX0 … digit3 → HEX3). It sits directly upstream of the hex decoders. It takes button/switch levels, derives a selectable count rate from the 50 MHz board clock, and steps a hex or BCD count up or down. Output nibbles are registered and drive the decoders directly, with no further glue.

---
 rtl/display_counter.sv | 173 +++++++++++++++++
 tb/tb_display_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/display_counter.sv
// Four-digit start/stop counter feeding the per-digit hex decoders.
// Hex or BCD digits, up or down, with a selectable tick rate derived from the board clock.
module display_counter #(
    parameter int DIV = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    input  logic        start,
    input  logic        stop,
    input  logic        load,
    input  logic [1:0]  speed,
    input  logic        bcd_mode,
    input  logic        down,
    input  logic [15:0] load_val,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic        running,
    output logic        tick,
    output logic        wrap
);

    localparam int DW = $clog2(4 * DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t          state_reg;
    logic            running_reg;
    logic [DW-1:0]   div_reg;
    logic [DW-1:0]   period_m1;
    logic [1:0]      speed_reg;
    logic [2:0]      in_reg;
    logic [2:0]      in_prev_reg;
    logic [2:0]      armed_reg;
    logic [2:0]      req;
    logic            start_req;
    logic            stop_req;
    logic            load_req;
    logic [3:0]      digit_reg [4];
    logic [3:0]      step_val  [4];
    logic [3:0]      load_nib  [4];
    logic [4:0]      carry;
    logic [3:0]      max_digit;

    // armed_reg masks inputs that were already high when reset released,
    // until they have been sampled low at least once.
    assign req       = in_reg & ~in_prev_reg & armed_reg;
    assign start_req = req[0];
    assign stop_req  = req[1];
    assign load_req  = req[2];

    assign max_digit = bcd_mode ? 4'd9 : 4'd15;

    always_comb begin
        case (speed)
            2'b00:   period_m1 = '0;
            2'b01:   period_m1 = DW'(DIV - 1);
            2'b10:   period_m1 = DW'(2 * DIV - 1);
            default: period_m1 = DW'(4 * DIV - 1);
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_load
            assign load_nib[gi] = (bcd_mode && load_val[4*gi +: 4] > 4'd9)
                                ? 4'd9 : load_val[4*gi +: 4];
        end
    endgenerate

    // Ripple carry/borrow chain; carry[4] is the roll-over out of digit3.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_val[i] = digit_reg[i];
            if (carry[i]) begin
                if (!down) begin
                    if (digit_reg[i] >= max_digit) begin
                        step_val[i] = 4'd0;
                        carry[i+1]  = 1'b1;
                    end else begin
                        step_val[i] = digit_reg[i] + 4'd1;
                    end
                end else begin
                    if (digit_reg[i] == 4'd0) begin
                        step_val[i] = max_digit;
                        carry[i+1]  = 1'b1;
                    end else if (digit_reg[i] > max_digit) begin
                        step_val[i] = max_digit - 4'd1;
                    end else begin
                        step_val[i] = digit_reg[i] - 4'd1;
                    end
                end
            end
        end
    end

    assign tick    = (state_reg == RUN) && (div_reg == '0);
    assign wrap    = tick && carry[4];
    assign running = running_reg;
    assign digit0  = digit_reg[0];
    assign digit1  = digit_reg[1];
    assign digit2  = digit_reg[2];
    assign digit3  = digit_reg[3];

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_reg   <= IDLE;
            running_reg <= 1'b0;
            div_reg     <= '0;
            speed_reg   <= 2'b00;
            in_reg      <= '0;
            in_prev_reg <= '0;
            armed_reg   <= '0;
            for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
        end else begin
            in_reg      <= {load, stop, start};
            in_prev_reg <= in_reg;
            armed_reg   <= armed_reg | ~{load, stop, start};
            speed_reg   <= speed;

            case (state_reg)
                IDLE: begin
                    if (load_req)
                        for (int i = 0; i < 4; i++) digit_reg[i] <= load_nib[i];
                    if (start_req && !stop_req) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop_req) begin
                        state_reg   <= PAUSED;
                        running_reg <= 1'b0;
                    end else if (tick) begin
                        for (int i = 0; i < 4; i++) digit_reg[i] <= step_val[i];
                    end
                end
                PAUSED: begin
                    if (stop_req) begin
                        state_reg <= IDLE;
                        for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
                    end else begin
                        if (load_req)
                            for (int i = 0; i < 4; i++) digit_reg[i] <= load_nib[i];
                        if (start_req) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                end
            endcase

            // Outside RUN the divider sits at period-1, so entry to RUN starts a full period.
            if (state_reg != RUN)
                div_reg <= period_m1;
            else if (speed != speed_reg || div_reg == '0)
                div_reg <= period_m1;
            else
                div_reg <= div_reg - DW'(1);
        end
    end

endmodule

// File: tb/tb_display_counter.sv
// Directed bench for display_counter: expectations are queued as stimulus is
// driven and popped one per clock as the counter produces output.
module tb_display_counter;

    logic        clk;
    logic        Resetn;
    logic        start, stop, load;
    logic [1:0]  speed;
    logic        bcd_mode, down;
    logic [15:0] load_val;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic        running, tick, wrap;
    logic [18:0] obs;

    typedef struct {
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    display_counter #(.DIV(5)) dut (
        .CLOCK_50 (clk),
        .Resetn   (Resetn),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .speed    (speed),
        .bcd_mode (bcd_mode),
        .down     (down),
        .load_val (load_val),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .running  (running),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {running, tick, wrap, digit3, digit2, digit1, digit0};

    function automatic logic [18:0] ev(input logic r, input logic t, input logic w,
                                       input logic [15:0] v);
        return {r, t, w, v};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [18:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            $display("[%0t] %s run=%b tick=%b wrap=%b digits=%h (exp %h)",
                     $time, e.tag, obs[18], obs[17], obs[16], obs[15:0], e.val);
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step_chk(input string tag, input logic [18:0] v);
        push(tag, v);
        cyc();
        compare_front();
    endtask

    initial begin
        Resetn = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
        speed = 2'b00; bcd_mode = 1'b1; down = 1'b0; load_val = 16'h0000;
        repeat (3) cyc();
        push("reset", ev(0, 0, 0, 16'h0000));
        compare_front();
        Resetn = 1'b1;
        cyc(); cyc();

        // Speed 00, BCD up: one step per clock once running
        start = 1'b1; step_chk("start_smp", ev(0, 0, 0, 16'h0000));
        start = 1'b0; step_chk("run_entry", ev(1, 1, 0, 16'h0000));
        for (int i = 1; i <= 3; i++) step_chk("count00", ev(1, 1, 0, 16'(i)));
        stop = 1'b1;  step_chk("stop_smp", ev(1, 1, 0, 16'h0004));
        stop = 1'b0;  step_chk("paused_no_step", ev(0, 0, 0, 16'h0004));
        step_chk("paused_hold", ev(0, 0, 0, 16'h0004));

        // Load while paused, resume, load in RUN ignored, double stop clears
        load_val = 16'h1234;
        load = 1'b1;  step_chk("load_smp", ev(0, 0, 0, 16'h0004));
        load = 1'b0;  step_chk("load_paused", ev(0, 0, 0, 16'h1234));
        start = 1'b1; step_chk("resume_smp", ev(0, 0, 0, 16'h1234));
        start = 1'b0; step_chk("resume", ev(1, 1, 0, 16'h1234));
        step_chk("resume_step", ev(1, 1, 0, 16'h1235));
        load_val = 16'h0000;
        load = 1'b1;  step_chk("run_load_smp", ev(1, 1, 0, 16'h1236));
        load = 1'b0;  step_chk("load_run_ignored", ev(1, 1, 0, 16'h1237));
        stop = 1'b1;  step_chk("stop2_smp", ev(1, 1, 0, 16'h1238));
        stop = 1'b0;  step_chk("paused2", ev(0, 0, 0, 16'h1238));
        stop = 1'b1;  step_chk("stop3_smp", ev(0, 0, 0, 16'h1238));
        stop = 1'b0;  step_chk("stop_paused_clear", ev(0, 0, 0, 16'h0000));

        // start and stop together from IDLE
        start = 1'b1; stop = 1'b1; step_chk("ss_smp", ev(0, 0, 0, 16'h0000));
        start = 1'b0; stop = 1'b0; step_chk("start_stop_idle", ev(0, 0, 0, 16'h0000));
        step_chk("start_stop_idle2", ev(0, 0, 0, 16'h0000));

        // BCD up wrap 9999 -> 0000
        load_val = 16'h9998;
        load = 1'b1;  step_chk("ld9998_smp", ev(0, 0, 0, 16'h0000));
        load = 1'b0;  step_chk("ld9998", ev(0, 0, 0, 16'h9998));
        start = 1'b1; step_chk("bcd_start_smp", ev(0, 0, 0, 16'h9998));
        start = 1'b0; step_chk("bcd_entry", ev(1, 1, 0, 16'h9998));
        step_chk("bcd_wrap", ev(1, 1, 1, 16'h9999));
        step_chk("bcd_roll", ev(1, 1, 0, 16'h0000));
        step_chk("bcd_after", ev(1, 1, 0, 16'h0001));
        stop = 1'b1;  step_chk("bcd_stop_smp", ev(1, 1, 0, 16'h0002));
        stop = 1'b0;  step_chk("bcd_paused", ev(0, 0, 0, 16'h0002));

        // Hex up wrap FFFF -> 0000
        bcd_mode = 1'b0; load_val = 16'hFFFE;
        load = 1'b1;  step_chk("ldFFFE_smp", ev(0, 0, 0, 16'h0002));
        load = 1'b0;  step_chk("ldFFFE", ev(0, 0, 0, 16'hFFFE));
        start = 1'b1; step_chk("hex_start_smp", ev(0, 0, 0, 16'hFFFE));
        start = 1'b0; step_chk("hex_entry", ev(1, 1, 0, 16'hFFFE));
        step_chk("hex_wrap", ev(1, 1, 1, 16'hFFFF));
        step_chk("hex_roll", ev(1, 1, 0, 16'h0000));
        stop = 1'b1;  step_chk("hex_stop_smp", ev(1, 1, 0, 16'h0001));
        stop = 1'b0;  step_chk("hex_paused", ev(0, 0, 0, 16'h0001));

        // BCD down wrap 0000 -> 9999, then clamped load
        bcd_mode = 1'b1; down = 1'b1; load_val = 16'h0000;
        load = 1'b1;  step_chk("ld0_smp", ev(0, 0, 0, 16'h0001));
        load = 1'b0;  step_chk("ld0", ev(0, 0, 0, 16'h0000));
        start = 1'b1; step_chk("down_start_smp", ev(0, 0, 0, 16'h0000));
        start = 1'b0; step_chk("down_wrap", ev(1, 1, 1, 16'h0000));
        step_chk("down_roll", ev(1, 1, 0, 16'h9999));
        step_chk("down_step", ev(1, 1, 0, 16'h9998));
        stop = 1'b1;  step_chk("down_stop_smp", ev(1, 1, 0, 16'h9997));
        stop = 1'b0;  step_chk("down_paused", ev(0, 0, 0, 16'h9997));
        load_val = 16'h12AF;
        load = 1'b1;  step_chk("clamp_smp", ev(0, 0, 0, 16'h9997));
        load = 1'b0;  step_chk("bcd_clamp", ev(0, 0, 0, 16'h1299));

        // Speed 01 (period 5), then speed 11 (period 20) changed mid-run
        down = 1'b0; speed = 2'b01;
        start = 1'b1; step_chk("div_start_smp", ev(0, 0, 0, 16'h1299));
        start = 1'b0;
        for (int i = 0; i < 11; i++)
            push("speed01", ev(1, (i % 5) == 4, 0,
                               (i < 5) ? 16'h1299 : ((i < 10) ? 16'h1300 : 16'h1301)));
        for (int i = 0; i < 11; i++) begin
            cyc();
            compare_front();
        end
        speed = 2'b11;
        for (int i = 0; i < 40; i++)
            push("speed11", ev(1, (i % 20) == 19, 0, 16'h1301 + 16'(i / 20)));
        for (int i = 0; i < 40; i++) begin
            cyc();
            compare_front();
        end

        // Asynchronous reset mid-run with start held through release
        start = 1'b1;
        #3;
        Resetn = 1'b0;
        #1;
        push("async_reset", ev(0, 0, 0, 16'h0000));
        compare_front();
        cyc(); cyc();
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) step_chk("held_start_ignored", ev(0, 0, 0, 16'h0000));
        start = 1'b0; step_chk("start_low", ev(0, 0, 0, 16'h0000));
        step_chk("start_low2", ev(0, 0, 0, 16'h0000));
        start = 1'b1; step_chk("restart_smp", ev(0, 0, 0, 16'h0000));
        step_chk("restart", ev(1, 0, 0, 16'h0000));
        step_chk("restart_div", ev(1, 0, 0, 16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
